md_sched: RTL and testbench

Controller between the EX stage and an iterative multiply/divide engine. Issues MULT/MULTU/DIV/DIVU/MUL to the engine with a start/done handshake and owns the architectural HI/LO registers. Generates the pipeline stall so independent instructions keep flowing while an operation runs, and stalls only on HI/LO hazards. Sits in EX beside the ALU; the engine is a separate module driven only by this block.

---
 rtl/md_sched_if.sv | 29 ++
 rtl/md_sched.sv | 159 +++++++++++++++
 tb/tb_md_sched.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// Signal bundle between the EX stage, md_sched and the iterative multiply/divide engine.
interface md_sched_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] Md_op;
  logic           Ex_valid;
  logic           Flush;
  logic [31:0]    Rs_in;
  logic [31:0]    Rt_in;
  logic [31:0]    Res_out;
  logic           Md_stall;
  logic           Eng_start;
  logic [1:0]     Eng_op;
  logic [31:0]    Eng_a;
  logic [31:0]    Eng_b;
  logic           Eng_done;
  logic [31:0]    Eng_hi;
  logic [31:0]    Eng_lo;

  modport slave (
    input  Md_op, Ex_valid, Flush, Rs_in, Rt_in, Eng_done, Eng_hi, Eng_lo,
    output Res_out, Md_stall, Eng_start, Eng_op, Eng_a, Eng_b
  );

  modport master (
    output Md_op, Ex_valid, Flush, Rs_in, Rt_in, Eng_done, Eng_hi, Eng_lo,
    input  Res_out, Md_stall, Eng_start, Eng_op, Eng_a, Eng_b
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: issues ops to the engine, owns HI/LO, stalls EX on HI/LO hazards.
// MD_NONBLOCK_EN defined: MULT/MULTU/DIV/DIVU issue without stalling EX; undefined: they stall like MUL.
module md_sched #(
  parameter int OPW = 4
) (
  input logic      Clk,
  input logic      Rst,
  md_sched_if.slave md
);

`ifdef MD_NONBLOCK_EN
  localparam bit NONBLOCK = 1'b1;
`else
  localparam bit NONBLOCK = 1'b0;
`endif

  localparam logic [OPW-1:0] OP_DIV   = OPW'(1);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(2);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(3);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(4);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(7);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(8);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(9);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MULDONE} state_t;
  typedef enum logic [1:0] {D_HILO, D_GPR, D_DISCARD} dst_t;

  state_t      state_reg, state_next;
  dst_t        dst_reg, dst_next;
  logic        hold_reg, hold_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] res_reg, res_next;

  logic        live, kill;
  logic        op_div, op_divu, op_mult, op_multu, op_mul;
  logic        op_mfhi, op_mflo, op_mthi, op_mtlo, op_hilo, op_mf, op_mt;
  logic        stall, start;
  logic [31:0] res_out;
  logic [1:0]  eng_op;

  assign live     = md.Ex_valid & ~md.Flush;
  assign kill     = md.Ex_valid & md.Flush;
  assign op_div   = (md.Md_op == OP_DIV);
  assign op_divu  = (md.Md_op == OP_DIVU);
  assign op_mfhi  = (md.Md_op == OP_MFHI);
  assign op_mflo  = (md.Md_op == OP_MFLO);
  assign op_mthi  = (md.Md_op == OP_MTHI);
  assign op_mtlo  = (md.Md_op == OP_MTLO);
  assign op_mul   = (md.Md_op == OP_MUL);
  assign op_mult  = (md.Md_op == OP_MULT);
  assign op_multu = (md.Md_op == OP_MULTU);
  assign op_hilo  = op_div | op_divu | op_mult | op_multu;
  assign op_mf    = op_mfhi | op_mflo;
  assign op_mt    = op_mthi | op_mtlo;

  always_comb begin
    eng_op = 2'b10;
    if (op_div)        eng_op = 2'b00;
    else if (op_divu)  eng_op = 2'b01;
    else if (op_multu) eng_op = 2'b11;
  end

  // hold_reg marks a blocking-mode HI/LO op still waiting in EX for its release cycle.
  always_comb begin
    state_next = state_reg;
    dst_next   = dst_reg;
    hold_next  = hold_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    res_next   = res_reg;
    stall      = 1'b0;
    start      = 1'b0;
    res_out    = 32'h0;
    case (state_reg)
      S_IDLE: begin
        if (live) begin
          if (op_mul) begin
            start      = 1'b1;
            stall      = 1'b1;
            state_next = S_RUN;
            dst_next   = D_GPR;
            hold_next  = 1'b0;
          end else if (op_hilo) begin
            start      = 1'b1;
            stall      = !NONBLOCK;
            state_next = S_RUN;
            dst_next   = D_HILO;
            hold_next  = !NONBLOCK;
          end else if (op_mthi) begin
            hi_next = md.Rs_in;
          end else if (op_mtlo) begin
            lo_next = md.Rs_in;
          end else if (op_mfhi) begin
            res_out = hi_reg;
          end else if (op_mflo) begin
            res_out = lo_reg;
          end
        end
      end
      S_RUN: begin
        if (live && (op_mul || op_hilo || op_mf || op_mt)) stall = 1'b1;
        // A killed EX op in RUN is the waiting issuer; HI/LO ops still complete.
        if (kill) begin
          hold_next = 1'b0;
          if (dst_reg == D_GPR) dst_next = D_DISCARD;
        end
        if (md.Eng_done) begin
          case (dst_next)
            D_HILO: begin
              hi_next    = md.Eng_hi;
              lo_next    = md.Eng_lo;
              state_next = hold_next ? S_MULDONE : S_IDLE;
            end
            D_GPR: begin
              res_next   = md.Eng_lo;
              state_next = S_MULDONE;
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_MULDONE: begin
        if (dst_reg == D_GPR) res_out = res_reg;
        hold_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= S_IDLE;
      dst_reg   <= D_HILO;
      hold_reg  <= 1'b0;
      hi_reg    <= 32'h0;
      lo_reg    <= 32'h0;
      res_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      dst_reg   <= dst_next;
      hold_reg  <= hold_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      res_reg   <= res_next;
    end
  end

  assign md.Res_out   = res_out;
  assign md.Md_stall  = stall;
  assign md.Eng_start = start;
  assign md.Eng_op    = eng_op;
  assign md.Eng_a     = md.Rs_in;
  assign md.Eng_b     = md.Rt_in;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: behavioural engine, program-order vector table, corner sequences.
module tb_md_sched;
  localparam int OPW = 4;
`ifdef MD_NONBLOCK_EN
  localparam bit NB = 1'b1;
`else
  localparam bit NB = 1'b0;
`endif

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MFHI  = 4'd3;
  localparam logic [3:0] OP_MFLO  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_BAD   = 4'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_sched_if #(.OPW(OPW)) ifc ();
  md_sched #(.OPW(OPW)) dut (.Clk(clk), .Rst(rst), .md(ifc));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: done arrives eng_lat cycles after the start strobe.
  int          eng_lat = 1;
  bit          eng_active = 1'b0;
  int          done_at = 0;
  int          last_done = -100;
  bit          manual_done = 1'b0;
  logic [1:0]  e_op;
  logic [31:0] e_a, e_b;

  function automatic logic [63:0] eng_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00:   eng_calc = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      2'b01:   eng_calc = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      2'b10:   eng_calc = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      default: eng_calc = {32'h0, a} * {32'h0, b};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      eng_active = 1'b0;
    end else begin
      if (eng_active && cyc == done_at) eng_active = 1'b0;
      if (ifc.Eng_start) begin
        eng_active = 1'b1;
        done_at    = cyc + eng_lat;
        e_op       = ifc.Eng_op;
        e_a        = ifc.Eng_a;
        e_b        = ifc.Eng_b;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (eng_active && cyc == done_at) begin
      {ifc.Eng_hi, ifc.Eng_lo} = eng_calc(e_op, e_a, e_b);
      ifc.Eng_done = 1'b1;
      last_done    = cyc;
    end else begin
      ifc.Eng_hi   = 32'hDEADBEEF;
      ifc.Eng_lo   = 32'hDEADBEEF;
      ifc.Eng_done = manual_done;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected Res_out queued when an instruction is presented, popped when it leaves EX.
  logic [31:0] exp_q[$];

  task automatic run_instr(input string name, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input int lat, input logic [31:0] exp,
                           input int exp_stalls);
    bit          has_res;
    bit          retired;
    int          stalls;
    logic [31:0] e;
    has_res = (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MUL);
    eng_lat = lat;
    ifc.Ex_valid = 1'b1;
    ifc.Flush    = 1'b0;
    ifc.Md_op    = op;
    ifc.Rs_in    = rs;
    ifc.Rt_in    = rt;
    if (has_res) exp_q.push_back(exp);
    stalls  = 0;
    retired = 1'b0;
    for (int k = 0; k < 40 && !retired; k++) begin
      @(negedge clk);
      if (ifc.Md_stall) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        retired = 1'b1;
      end
    end
    if (!retired) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, want retire", name, stalls);
    end else begin
      check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    end
    if (has_res) begin
      e = exp_q.pop_front();
      if (retired) check({name, "_res"}, ifc.Res_out, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ifc.Ex_valid = 1'b0;
    ifc.Flush    = 1'b0;
    ifc.Md_op    = OP_NONE;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [31:0] exp;
    int          st_nb;
    int          st_bl;
  } vec_t;

  vec_t tbl[26];

  initial begin
    bit got;
    ifc.Ex_valid = 1'b0;
    ifc.Flush    = 1'b0;
    ifc.Md_op    = OP_NONE;
    ifc.Rs_in    = 32'h0;
    ifc.Rt_in    = 32'h0;

    //          op        rs            rt            lat exp           nb bl
    tbl[0]  = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 3, 32'h0,        0, 4};
    tbl[1]  = '{OP_MFLO,  32'h0,        32'h0,        1, 32'hFFFFFFEB, 3, 0};
    tbl[2]  = '{OP_MFHI,  32'h0,        32'h0,        1, 32'hFFFFFFFF, 0, 0};
    tbl[3]  = '{OP_DIVU,  32'd100,      32'd7,        3, 32'h0,        0, 4};
    tbl[4]  = '{OP_NONE,  32'h0,        32'h0,        1, 32'h0,        0, 0};
    tbl[5]  = '{OP_NONE,  32'h0,        32'h0,        1, 32'h0,        0, 0};
    tbl[6]  = '{OP_NONE,  32'h0,        32'h0,        1, 32'h0,        0, 0};
    tbl[7]  = '{OP_MFLO,  32'h0,        32'h0,        1, 32'd14,       0, 0};
    tbl[8]  = '{OP_MFHI,  32'h0,        32'h0,        1, 32'd2,        0, 0};
    tbl[9]  = '{OP_DIVU,  32'hFFFFFFF0, 32'd3,        2, 32'h0,        0, 3};
    tbl[10] = '{OP_MFLO,  32'h0,        32'h0,        1, 32'h55555550, 2, 0};
    tbl[11] = '{OP_MFHI,  32'h0,        32'h0,        1, 32'h0,        0, 0};
    tbl[12] = '{OP_MTHI,  32'hA5A5A5A5, 32'h0,        1, 32'h0,        0, 0};
    tbl[13] = '{OP_MUL,   32'h00010000, 32'h00010003, 2, 32'h00030000, 3, 3};
    tbl[14] = '{OP_MFHI,  32'h0,        32'h0,        1, 32'hA5A5A5A5, 0, 0};
    tbl[15] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        4, 32'h0,        0, 5};
    tbl[16] = '{OP_MTLO,  32'h00001234, 32'h0,        1, 32'h0,        4, 0};
    tbl[17] = '{OP_MFHI,  32'h0,        32'h0,        1, 32'hFFFFFFFE, 0, 0};
    tbl[18] = '{OP_MFLO,  32'h0,        32'h0,        1, 32'h00001234, 0, 0};
    tbl[19] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        1, 32'h0,        0, 2};
    tbl[20] = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        2, 32'h0,        1, 3};
    tbl[21] = '{OP_MFHI,  32'h0,        32'h0,        1, 32'hFFFFFFFF, 2, 0};
    tbl[22] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'h0,        0, 3};
    tbl[23] = '{OP_MFHI,  32'h0,        32'h0,        1, 32'hFFFFFFFE, 2, 0};
    tbl[24] = '{OP_BAD,   32'h0,        32'h0,        1, 32'h0,        0, 0};
    tbl[25] = '{OP_MFLO,  32'h0,        32'h0,        1, 32'h00000001, 0, 0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(ifc.Md_stall), 32'd0);
    check("rst_start", 32'(ifc.Eng_start), 32'd0);
    check("rst_res", ifc.Res_out, 32'h0);
    @(posedge clk);
    #1;
    run_instr("rst_hi", OP_MFHI, 32'h0, 32'h0, 1, 32'h0, 0);
    run_instr("rst_lo", OP_MFLO, 32'h0, 32'h0, 1, 32'h0, 0);
    bubble();

    // MUL issue strobe, operands and latency
    eng_lat = 3;
    ifc.Ex_valid = 1'b1;
    ifc.Md_op    = OP_MUL;
    ifc.Rs_in    = 32'd3;
    ifc.Rt_in    = 32'd5;
    @(negedge clk);
    check("mul_start", 32'(ifc.Eng_start), 32'd1);
    check("mul_eng_op", 32'(ifc.Eng_op), 32'd2);
    check("mul_eng_a", ifc.Eng_a, 32'd3);
    check("mul_eng_b", ifc.Eng_b, 32'd5);
    check("mul_issue_stall", 32'(ifc.Md_stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mul_run_start", 32'(ifc.Eng_start), 32'd0);
    check("mul_run_stall", 32'(ifc.Md_stall), 32'd1);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!ifc.Md_stall) got = 1'b1;
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("FAIL mul_timeout: stall never released, want release at done+1");
    end else begin
      check("mul_res", ifc.Res_out, 32'd15);
      check("mul_release_cycle", 32'(cyc), 32'(last_done + 1));
    end
    @(posedge clk);
    #1;
    ifc.Ex_valid = 1'b0;
    ifc.Md_op    = OP_NONE;
    @(negedge clk);
    check("mul_after_res", ifc.Res_out, 32'h0);
    @(posedge clk);
    #1;

    // Program-order vector table
    for (int i = 0; i < 26; i++) begin
      run_instr($sformatf("row%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].lat,
                tbl[i].exp, NB ? tbl[i].st_nb : tbl[i].st_bl);
    end
    bubble();

    // Flush on the MUL's second stalled cycle: result dropped, HI/LO untouched
    eng_lat = 4;
    ifc.Ex_valid = 1'b1;
    ifc.Md_op    = OP_MUL;
    ifc.Rs_in    = 32'd2;
    ifc.Rt_in    = 32'd3;
    @(negedge clk);
    check("flush_first_stall", 32'(ifc.Md_stall), 32'd1);
    @(posedge clk);
    #1;
    ifc.Flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", 32'(ifc.Md_stall), 32'd0);
    check("flush_no_start", 32'(ifc.Eng_start), 32'd0);
    @(posedge clk);
    #1;
    run_instr("flush_mfhi", OP_MFHI, 32'h0, 32'h0, 1, 32'hFFFFFFFE, 3);
    run_instr("flush_mflo", OP_MFLO, 32'h0, 32'h0, 1, 32'h00000001, 0);
    bubble();

    // Reset during a DIV in RUN; a late done must be ignored
    eng_lat = 5;
    ifc.Ex_valid = 1'b1;
    ifc.Md_op    = OP_DIV;
    ifc.Rs_in    = 32'd100;
    ifc.Rt_in    = 32'd7;
    @(negedge clk);
    check("rdiv_start", 32'(ifc.Eng_start), 32'd1);
    @(posedge clk);
    #1;
    ifc.Ex_valid = 1'b0;
    ifc.Md_op    = OP_NONE;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rdiv_stall", 32'(ifc.Md_stall), 32'd0);
    check("rdiv_start_low", 32'(ifc.Eng_start), 32'd0);
    check("rdiv_res", ifc.Res_out, 32'h0);
    @(posedge clk);
    #1;
    manual_done  = 1'b1;
    ifc.Ex_valid = 1'b1;
    ifc.Md_op    = OP_MFHI;
    @(negedge clk);
    check("late_done_stall", 32'(ifc.Md_stall), 32'd0);
    check("late_done_hi", ifc.Res_out, 32'h0);
    @(posedge clk);
    #1;
    manual_done = 1'b0;
    ifc.Md_op   = OP_MFLO;
    @(negedge clk);
    check("late_done_lo_stall", 32'(ifc.Md_stall), 32'd0);
    check("late_done_lo", ifc.Res_out, 32'h0);
    @(posedge clk);
    #1;
    ifc.Md_op = OP_MFHI;
    @(negedge clk);
    check("late_done_hi2", ifc.Res_out, 32'h0);
    @(posedge clk);
    #1;
    bubble();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end
endmodule
